// File: rtl/calc_sched.sv
// calc_sched: per-job sequencer for the 16-lane 3x3 calculation array.
// The next beat is decided one cycle ahead so every array-facing output comes straight from a flop.
module calc_sched #(
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 16,
  parameter int CREDIT = 32
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [7:0]        cfg_acc_para,
  input  logic [PIX_W-1:0]  cfg_pix_num,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_d_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_w_addr,
  output logic [ADDR_W-1:0] rd_d_addr,
  output logic              calc_vld,
  output logic              calc_new_start,
  output logic [7:0]        calc_acc_para,
  input  logic              res_vld,
  input  logic              res_pop
);

  localparam int CW = $clog2(CREDIT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          acc_q, acc_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [ADDR_W-1:0]   wb_q, wb_d;
  logic [7:0]          k_q, k_d;
  logic [PIX_W-1:0]    p_q, p_d;
  logic [ADDR_W-1:0]   dptr_q, dptr_d;
  logic [PIX_W-1:0]    r_q, r_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_k0_q, rd_k0_d;
  logic [ADDR_W-1:0]   rd_w_addr_q, rd_w_addr_d;
  logic [ADDR_W-1:0]   rd_d_addr_q, rd_d_addr_d;
  logic                calc_vld_q, calc_vld_d;
  logic                calc_new_start_q, calc_new_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Beat position seen by the issue decision: the config bus when starting, else the job registers.
  logic [7:0]          cur_k, cur_acc;
  logic [PIX_W-1:0]    cur_p, cur_pix;
  logic [ADDR_W-1:0]   cur_ptr, cur_wb;
  logic                pop_eff, credit_inc, res_cnt;

  // Next-state, counter, credit and issue logic.
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    pix_d            = pix_q;
    wb_d             = wb_q;
    k_d              = k_q;
    p_d              = p_q;
    dptr_d           = dptr_q;
    rd_en_d          = 1'b0;
    rd_k0_d          = 1'b0;
    rd_w_addr_d      = rd_w_addr_q;
    rd_d_addr_d      = rd_d_addr_q;
    calc_vld_d       = rd_en_q;
    calc_new_start_d = rd_en_q & rd_k0_q;
    cur_k            = k_q;
    cur_acc          = acc_q;
    cur_p            = p_q;
    cur_pix          = pix_q;
    cur_ptr          = dptr_q;
    cur_wb           = wb_q;

    pop_eff    = res_pop & (credit_q != {CW{1'b0}});
    credit_inc = rd_en_q & rd_k0_q;
    if (credit_inc && !pop_eff) begin
      credit_d = credit_q + CW'(1);
    end else if (!credit_inc && pop_eff) begin
      credit_d = credit_q - CW'(1);
    end else begin
      credit_d = credit_q;
    end

    res_cnt = res_vld & ((state_q == RUN) | (state_q == DRAIN));
    r_d     = r_q + PIX_W'(res_cnt);

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          acc_d   = cfg_acc_para;
          pix_d   = cfg_pix_num;
          wb_d    = cfg_w_base;
          k_d     = 8'd0;
          p_d     = {PIX_W{1'b0}};
          r_d     = {PIX_W{1'b0}};
          dptr_d  = cfg_d_base;
          cur_k   = 8'd0;
          cur_acc = cfg_acc_para;
          cur_p   = {PIX_W{1'b0}};
          cur_pix = cfg_pix_num;
          cur_ptr = cfg_d_base;
          cur_wb  = cfg_w_base;
          state_d = (cfg_pix_num == {PIX_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // p reaches pix_num in the same cycle the last beat is on rd_en.
        if (p_q == pix_q) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (r_d == pix_q) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pixel may only be opened when the result buffer has room; mid-pixel beats never wait.
    if ((state_d == RUN) && (cur_p != cur_pix) &&
        ((cur_k != 8'd0) || (credit_d < CREDIT_MAX))) begin
      rd_en_d     = 1'b1;
      rd_k0_d     = (cur_k == 8'd0);
      rd_w_addr_d = cur_wb + ADDR_W'(cur_k);
      rd_d_addr_d = cur_ptr;
      dptr_d      = cur_ptr + ADDR_W'(1);
      if (cur_k == cur_acc) begin
        k_d = 8'd0;
        p_d = cur_p + PIX_W'(1);
      end else begin
        k_d = cur_k + 8'd1;
        p_d = cur_p;
      end
    end else begin
      rd_en_d = 1'b0;
      rd_k0_d = 1'b0;
    end

    busy_d = (state_d == RUN) | (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q          <= IDLE;
      acc_q            <= 8'd0;
      pix_q            <= {PIX_W{1'b0}};
      wb_q             <= {ADDR_W{1'b0}};
      k_q              <= 8'd0;
      p_q              <= {PIX_W{1'b0}};
      dptr_q           <= {ADDR_W{1'b0}};
      r_q              <= {PIX_W{1'b0}};
      credit_q         <= {CW{1'b0}};
      rd_en_q          <= 1'b0;
      rd_k0_q          <= 1'b0;
      rd_w_addr_q      <= {ADDR_W{1'b0}};
      rd_d_addr_q      <= {ADDR_W{1'b0}};
      calc_vld_q       <= 1'b0;
      calc_new_start_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      pix_q            <= pix_d;
      wb_q             <= wb_d;
      k_q              <= k_d;
      p_q              <= p_d;
      dptr_q           <= dptr_d;
      r_q              <= r_d;
      credit_q         <= credit_d;
      rd_en_q          <= rd_en_d;
      rd_k0_q          <= rd_k0_d;
      rd_w_addr_q      <= rd_w_addr_d;
      rd_d_addr_q      <= rd_d_addr_d;
      calc_vld_q       <= calc_vld_d;
      calc_new_start_q <= calc_new_start_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign rd_en          = rd_en_q;
  assign rd_w_addr      = rd_w_addr_q;
  assign rd_d_addr      = rd_d_addr_q;
  assign calc_vld       = calc_vld_q;
  assign calc_new_start = calc_new_start_q;
  assign calc_acc_para  = acc_q;

endmodule
